mio_arbiter: RTL and testbench
==============================

# mio_arbiter

Two-port arbiter and sequencer for the single-port data RAM (RAM_B) behind MIO_BUS. It shares the RAM between the CPU data path and a debug/loader port, inserts the RAM's synchronous read latency as wait states, and generates the CPU's MIO_ready handshake. Arbitration is round-robin, and exactly one transaction is in flight at any time.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width (matches RAM_B addra)
- RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
- clk  in  1  system clock (clk_100mhz domain); all state changes on the rising edge
- RSTN  in  1  reset, asynchronous and active-low
- cpu_req  in  1  CPU access request, level; hold until ack
- cpu_we  in  1  1 = write, 0 = read; sampled at grant
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data returned to the CPU
- cpu_ready  out  1  MIO_ready to the CPU
- dbg_req  in  1  debug/loader request, level
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  debug read data
- dbg_ack  out  1  one-cycle completion pulse for the debug port
- ram_addr  out  ADDR_W  to RAM addra
- ram_din  out  32  to RAM dina
- ram_we  out  1  to RAM wea
- ram_dout  in  32  from RAM douta
- busy  out  1  transaction in flight (state is not IDLE)
- owner  out  1  current or last grant (0 = CPU, 1 = debug)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, grant and latch the requester's we, addr and wdata into internal registers. Go to ISSUE.
  - If both requests are high, grant the port that is not `owner` (round-robin).
  - If one request is high, grant it regardless of `owner`.
- ISSUE: ram_addr and ram_din come from the latched registers. ram_we equals the latched we for this cycle only.
  - Write: go to DONE.
  - Read: go to WAIT.
- WAIT: lasts exactly RD_LAT cycles, counted by an internal counter. On the edge ending the last WAIT cycle, load ram_dout into the granted port's rdata register. Go to DONE.
- DONE: one cycle. Assert the completion signal to the owner, then go to IDLE.
  - Debug owner: dbg_ack = 1.
  - CPU owner: cpu_ready goes high via the combinational term below.
- cpu_ready = ~cpu_req | (state == DONE & owner == 0). The CPU is therefore never stalled when it is not accessing the RAM.
- ram_addr and ram_din hold the latched values from ISSUE through DONE; they are 0 in IDLE. ram_we is 0 in every state except ISSUE.
- If a requester drops req mid-transaction, the transaction still completes and its ack is still issued.
- A requester that keeps req high through DONE is treated as making a new request in the following IDLE cycle.
- cpu_rdata and dbg_rdata keep their value until the next read for the same port. A write does not alter them.

## Timing
- Reset (RSTN = 0), effective asynchronously:
  - state = IDLE, owner = 1 (so the CPU wins the first tie), WAIT counter = 0.
  - ram_we = 0, ram_addr = 0, ram_din = 0.
  - cpu_rdata = 0, dbg_rdata = 0, dbg_ack = 0, busy = 0.
  - cpu_ready = ~cpu_req.
- Reset asserted mid-transaction aborts it immediately: no ack is issued, any pending write is dropped (ram_we falls asynchronously), and the FSM resumes in IDLE after release.
- Write latency, with req sampled high on edge 0: ISSUE in cycle 1 (ram_we = 1), DONE/ack in cycle 2. Total 3 cycles from req to IDLE.
- Read latency: ISSUE in cycle 1, WAIT in cycles 2..1+RD_LAT, DONE in cycle 2+RD_LAT with rdata already valid.
- Throughput: one transaction per 3 (write) or 3+RD_LAT (read) cycles. There is a mandatory IDLE cycle between transactions.
- Arbitration is decided only in IDLE. Requests that arrive during ISSUE, WAIT or DONE wait for the next IDLE.
- Worst-case wait for either port, with the other port saturating: one foreign transaction.

## Test plan
- Reset then CPU read: preload RAM[0x005] = 0xDEADBEEF; RD_LAT = 1; cpu_req = 1, cpu_we = 0, cpu_addr = 0x005.
  - Required: cpu_ready low for 3 cycles, high in cycle 3; cpu_rdata = 0xDEADBEEF in that cycle.
- Debug write then CPU read of the same word: dbg writes 0x12345678 to 0x3FF.
  - Required: ram_we = 1 for exactly one cycle with ram_addr = 0x3FF; dbg_ack pulses in cycle 2.
  - Then a CPU read of 0x3FF returns 0x12345678.
- Simultaneous requests held high for 4 transactions: starting from reset, grants alternate CPU, DBG, CPU, DBG.
  - Required: `owner` toggles; each ack is a single cycle; no port is granted twice in a row.
- cpu_req low with random debug traffic: cpu_ready stays 1 on every cycle.
- Reset mid-WAIT: RD_LAT = 3; assert RSTN = 0 in the second WAIT cycle.
  - Required: no dbg_ack, dbg_rdata = 0, busy = 0 immediately; after release the next request completes normally.
- Request dropped after grant: dbg_req pulses high for one cycle.
  - Required: the write still executes, and dbg_ack still pulses 2 cycles later.

Source files
------------

// File: rtl/mio_arbiter_if.sv
// Bus bundle between the MIO arbiter, its two requesters (CPU, debug/loader)
// and the single-port data RAM. The arbiter sits on the slave side.
interface mio_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output ram_addr, ram_din, ram_we,
        input  ram_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  ram_addr, ram_din, ram_we,
        output ram_dout
    );
endinterface

// File: rtl/mio_arbiter.sv
// Round-robin arbiter/sequencer sharing RAM_B between the CPU and the debug port,
// one transaction in flight, read latency absorbed as WAIT cycles.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// ISSUE | drive latched address/data to RAM, ram_we pulses for writes
// WAIT  | RD_LAT cycles of RAM read latency, rdata captured on the last
// DONE  | completion to owner (dbg_ack or cpu_ready), then back to IDLE
module mio_arbiter #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           RSTN,
    mio_arbiter_if.slave   bus,
    output logic           busy,
    output logic           owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t            state;
    logic [1:0]        wait_cnt;
    logic              owner_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_din_q;
    logic [31:0]       cpu_rdata_q;
    logic [31:0]       dbg_rdata_q;
    logic              dbg_ack_q;
    logic              grant_dbg;

    // On a tie the port that did not win last time gets the RAM.
    assign grant_dbg = bus.dbg_req & (~bus.cpu_req | ~owner_q);

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            wait_cnt    <= 2'd0;
            owner_q     <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req | bus.dbg_req) begin
                        owner_q    <= grant_dbg;
                        ram_we_q   <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
                        ram_addr_q <= grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                        ram_din_q  <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we_q <= 1'b0;
                    if (ram_we_q) begin
                        dbg_ack_q <= owner_q;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        if (owner_q) begin
                            dbg_rdata_q <= bus.ram_dout;
                        end else begin
                            cpu_rdata_q <= bus.ram_dout;
                        end
                        dbg_ack_q <= owner_q;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    ram_addr_q <= '0;
                    ram_din_q  <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A CPU that is not requesting must never see a stall.
    assign bus.cpu_ready = ~bus.cpu_req | ((state == DONE) & ~owner_q);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_we    = ram_we_q;
    assign busy          = (state != IDLE);
    assign owner         = owner_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: directed scenarios plus random traffic checked against
// a transaction-timeline reference model; a second instance uses RD_LAT = 3.
module tb_mio_arbiter;

    localparam int AW = 10;
    localparam int L1 = 1;

    logic clk = 1'b0;
    logic RSTN;
    always #5 clk = ~clk;

    mio_arbiter_if #(.ADDR_W(AW)) b1 ();
    mio_arbiter_if #(.ADDR_W(AW)) b3 ();
    logic busy1, owner1, busy3, owner3;

    mio_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .RSTN(RSTN), .bus(b1.slave), .busy(busy1), .owner(owner1)
    );
    mio_arbiter #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .RSTN(RSTN), .bus(b3.slave), .busy(busy3), .owner(owner3)
    );

    // RAM models: latency 1 for u_dut1, latency 3 for u_dut3, with bench preload.
    logic [31:0]   mem1 [1024];
    logic [31:0]   mem3 [1024];
    logic [31:0]   p3_0, p3_1;
    logic          pre1_we, pre3_we, pre_clr;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= '0;
        end else if (pre1_we) begin
            mem1[pre_addr] <= pre_data;
        end else if (b1.ram_we) begin
            mem1[b1.ram_addr] <= b1.ram_din;
        end
        b1.ram_dout <= mem1[b1.ram_addr];
    end

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= '0;
        end else if (pre3_we) begin
            mem3[pre_addr] <= pre_data;
        end else if (b3.ram_we) begin
            mem3[b3.ram_addr] <= b3.ram_din;
        end
        p3_0        <= mem3[b3.ram_addr];
        p3_1        <= p3_0;
        b3.ram_dout <= p3_1;
    end

    int total = 0;
    int bad   = 0;

    // Reference model of u_dut1: one transaction record with a phase number
    // (1 = issue cycle, completion at phase 2 for writes, 2+L1 for reads).
    bit            m_act;
    int            m_ph;
    logic          m_own, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wd, m_crd, m_drd;
    logic [31:0]   ref_mem [1024];
    logic          e_busy, e_done, e_ram_we, e_dbg_ack, e_cpu_ready;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_din;
    logic [110:0]  got, exp;

    task automatic model_reset();
        m_act = 1'b0;
        m_ph  = 0;
        m_own = 1'b1;
        m_crd = '0;
        m_drd = '0;
    endtask

    task automatic model_eval();
        e_busy      = m_act;
        e_done      = m_act && (m_ph == (m_we ? 2 : 2 + L1));
        e_ram_we    = m_act && (m_ph == 1) && m_we;
        e_addr      = m_act ? m_addr : '0;
        e_din       = m_act ? m_wd : '0;
        e_dbg_ack   = e_done && m_own;
        e_cpu_ready = !b1.cpu_req || (e_done && !m_own);
        got = {busy1, owner1, b1.ram_we, b1.dbg_ack, b1.cpu_ready,
               b1.ram_addr, b1.ram_din, b1.cpu_rdata, b1.dbg_rdata};
        exp = {e_busy, m_own, e_ram_we, e_dbg_ack, e_cpu_ready,
               e_addr, e_din, m_crd, m_drd};
    endtask

    task automatic model_advance();
        if (!RSTN) begin
            model_reset();
        end else if (m_act) begin
            if (m_ph == 1 && m_we) ref_mem[m_addr] = m_wd;
            if (!m_we && m_ph == 1 + L1) begin
                if (m_own) m_drd = ref_mem[m_addr];
                else       m_crd = ref_mem[m_addr];
            end
            if (m_ph == (m_we ? 2 : 2 + L1)) m_act = 1'b0;
            else                             m_ph  = m_ph + 1;
        end else if (b1.cpu_req || b1.dbg_req) begin
            m_own  = (b1.cpu_req && b1.dbg_req) ? !m_own : b1.dbg_req;
            m_we   = m_own ? b1.dbg_we    : b1.cpu_we;
            m_addr = m_own ? b1.dbg_addr  : b1.cpu_addr;
            m_wd   = m_own ? b1.dbg_wdata : b1.cpu_wdata;
            m_act  = 1'b1;
            m_ph   = 1;
        end
    endtask

    // Every cycle starts 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic preload1(input logic [AW-1:0] a, input logic [31:0] d);
        pre_addr = a; pre_data = d; pre1_we = 1'b1;
        ref_mem[a] = d;
        tick();
        pre1_we = 1'b0;
    endtask

    task automatic preload3(input logic [AW-1:0] a, input logic [31:0] d);
        pre_addr = a; pre_data = d; pre3_we = 1'b1;
        tick();
        pre3_we = 1'b0;
    endtask

    task automatic drain();
        b1.cpu_req = 1'b0;
        b1.dbg_req = 1'b0;
        for (int i = 0; i < 10 && m_act; i++) tick();
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        {b1.cpu_req, b1.cpu_we, b1.dbg_req, b1.dbg_we} = '0;
        {b3.cpu_req, b3.cpu_we, b3.dbg_req, b3.dbg_we} = '0;
        b1.cpu_addr = '0; b1.cpu_wdata = '0; b1.dbg_addr = '0; b1.dbg_wdata = '0;
        b3.cpu_addr = '0; b3.cpu_wdata = '0; b3.dbg_addr = '0; b3.dbg_wdata = '0;
        pre1_we = 1'b0; pre3_we = 1'b0; pre_clr = 1'b1;
        pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        model_reset();
        @(posedge clk);
        #1;
        pre_clr = 1'b0;
        @(negedge clk);
        model_eval();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", got, exp);
        end
        total++;
        if ({busy1, owner1, b1.ram_we, b1.ram_addr, b1.ram_din, b1.dbg_ack} !== {1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_const busy=%b owner=%b we=%b addr=%h din=%h ack=%b exp busy=0 owner=1 rest 0",
                     busy1, owner1, b1.ram_we, b1.ram_addr, b1.ram_din, b1.dbg_ack);
        end
        total++;
        if ({busy3, owner3, b3.dbg_rdata} !== {1'b0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL reset_dut3 busy=%b owner=%b rdata=%h exp 0 1 0", busy3, owner3, b3.dbg_rdata);
        end
        b1.cpu_req = 1'b1;
        #1;
        total++;
        if (b1.cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_req got=%b exp=0", b1.cpu_ready);
        end
        b1.cpu_req = 1'b0;
        #1;
        RSTN = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        preload1(10'h005, 32'hDEADBEEF);
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 10'h005;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (b1.cpu_ready !== (c == 3)) begin
                bad++;
                $display("FAIL cpu_read_ready c=%0d got=%b exp=%b", c, b1.cpu_ready, (c == 3));
            end
            if (c == 3) begin
                total++;
                if (b1.cpu_rdata !== 32'hDEADBEEF) begin
                    bad++;
                    $display("FAIL cpu_read_data got=%h exp=deadbeef", b1.cpu_rdata);
                end
            end
            tick();
        end
        b1.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_dbg_write_cpu_read();
        b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 10'h3FF; b1.dbg_wdata = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (b1.ram_we !== (c == 1)) begin
                bad++;
                $display("FAIL dbg_wr_we c=%0d got=%b exp=%b", c, b1.ram_we, (c == 1));
            end
            if (c == 1) begin
                total++;
                if ({b1.ram_addr, b1.ram_din} !== {10'h3FF, 32'h12345678}) begin
                    bad++;
                    $display("FAIL dbg_wr_addr got=%h/%h exp=3ff/12345678", b1.ram_addr, b1.ram_din);
                end
            end
            total++;
            if (b1.dbg_ack !== (c == 2)) begin
                bad++;
                $display("FAIL dbg_wr_ack c=%0d got=%b exp=%b", c, b1.dbg_ack, (c == 2));
            end
            tick();
        end
        b1.dbg_req = 1'b0;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 10'h3FF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (b1.cpu_ready !== (c == 3)) begin
                bad++;
                $display("FAIL rd_back_ready c=%0d got=%b exp=%b", c, b1.cpu_ready, (c == 3));
            end
            if (c == 3) begin
                total++;
                if (b1.cpu_rdata !== 32'h12345678) begin
                    bad++;
                    $display("FAIL rd_back_data got=%h exp=12345678", b1.cpu_rdata);
                end
            end
            tick();
        end
        b1.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_req_drop();
        b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 10'h02A; b1.dbg_wdata = 32'hCAFE0042;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) b1.dbg_req = 1'b0;
            @(negedge clk);
            total++;
            if ({b1.ram_we, b1.dbg_ack} !== {(c == 1), (c == 2)}) begin
                bad++;
                $display("FAIL drop_we_ack c=%0d got=%b%b exp=%b%b", c, b1.ram_we, b1.dbg_ack, (c == 1), (c == 2));
            end
            tick();
        end
        total++;
        if (mem1[10'h02A] !== 32'hCAFE0042) begin
            bad++;
            $display("FAIL drop_mem got=%h exp=cafe0042", mem1[10'h02A]);
        end
    endtask

    task automatic test_round_robin();
        int seq [4];
        int n;
        do_reset();
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 10'h010; b1.cpu_wdata = 32'hC0C00001;
        b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 10'h011; b1.dbg_wdata = 32'hD0D00002;
        n = 0;
        for (int c = 0; c < 24 && n < 4; c++) begin
            @(negedge clk);
            model_eval();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rr_cycle%0d got=%h exp=%h", c, got, exp);
            end
            if (b1.dbg_ack === 1'b1) begin
                seq[n] = 1; n++;
            end else if (b1.cpu_ready === 1'b1) begin
                seq[n] = 0; n++;
            end
            tick();
        end
        b1.cpu_req = 1'b0;
        b1.dbg_req = 1'b0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rr_ack_count got=%0d exp=4", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (seq[i] != (i % 2)) begin
                bad++;
                $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, seq[i], i % 2);
            end
        end
        drain();
    endtask

    task automatic test_cpu_idle_ready();
        b1.cpu_req = 1'b0;
        for (int c = 0; c < 60; c++) begin
            b1.dbg_req   = 1'($urandom_range(0, 1));
            b1.dbg_we    = 1'($urandom_range(0, 1));
            b1.dbg_addr  = 10'($urandom_range(0, 15));
            b1.dbg_wdata = $urandom();
            @(negedge clk);
            model_eval();
            total++;
            if (b1.cpu_ready !== 1'b1) begin
                bad++;
                $display("FAIL idle_ready c=%0d got=%b exp=1", c, b1.cpu_ready);
            end
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL idle_cycle%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            b1.cpu_req   = 1'($urandom_range(0, 1));
            b1.cpu_we    = 1'($urandom_range(0, 1));
            b1.cpu_addr  = 10'($urandom_range(0, 15));
            b1.cpu_wdata = $urandom();
            b1.dbg_req   = 1'($urandom_range(0, 1));
            b1.dbg_we    = 1'($urandom_range(0, 1));
            b1.dbg_addr  = 10'($urandom_range(0, 15));
            b1.dbg_wdata = $urandom();
            @(negedge clk);
            model_eval();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand_cycle%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid_wait();
        preload3(10'h007, 32'hA5A50F0F);
        preload3(10'h009, 32'h11112222);
        b3.dbg_we = 1'b0; b3.dbg_addr = 10'h007; b3.dbg_req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) b3.dbg_req = 1'b0;
            @(negedge clk);
            total++;
            if (b3.dbg_ack !== (c == 5)) begin
                bad++;
                $display("FAIL lat3_ack c=%0d got=%b exp=%b", c, b3.dbg_ack, (c == 5));
            end
            if (c == 5) begin
                total++;
                if (b3.dbg_rdata !== 32'hA5A50F0F) begin
                    bad++;
                    $display("FAIL lat3_data got=%h exp=a5a50f0f", b3.dbg_rdata);
                end
            end
            tick();
        end
        b3.dbg_addr = 10'h009; b3.dbg_req = 1'b1;
        tick();
        b3.dbg_req = 1'b0;
        tick();
        tick();
        total++;
        if (busy3 !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before got=%b exp=1", busy3);
        end
        #2;
        RSTN = 1'b0;
        #1;
        total++;
        if ({busy3, b3.dbg_ack, b3.dbg_rdata, b3.ram_we, b3.ram_addr} !== {1'b0, 1'b0, 32'h0, 1'b0, 10'h0}) begin
            bad++;
            $display("FAIL abort_async busy=%b ack=%b rdata=%h we=%b addr=%h exp all 0",
                     busy3, b3.dbg_ack, b3.dbg_rdata, b3.ram_we, b3.ram_addr);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({busy3, b3.dbg_ack} !== 2'b00) begin
                bad++;
                $display("FAIL abort_quiet c=%0d busy=%b ack=%b exp 0 0", c, busy3, b3.dbg_ack);
            end
            if (c == 2) RSTN = 1'b1;
            tick();
        end
        b3.dbg_req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) b3.dbg_req = 1'b0;
            @(negedge clk);
            total++;
            if (b3.dbg_ack !== (c == 5)) begin
                bad++;
                $display("FAIL resume_ack c=%0d got=%b exp=%b", c, b3.dbg_ack, (c == 5));
            end
            if (c == 5) begin
                total++;
                if (b3.dbg_rdata !== 32'h11112222) begin
                    bad++;
                    $display("FAIL resume_data got=%h exp=11112222", b3.dbg_rdata);
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_req_drop();
        test_round_robin();
        test_cpu_idle_ready();
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
